// File: rtl/intirvx_decode_mw_pkg.sv
// Shared types for the multi-lane decode stage: CPU widths, decode control bus,
// decode-queue entry layout and the JAL offset helper.
package intirvx_decode_mw_pkg;

  localparam int xlen      = 32;
  localparam int alen      = 32;
  localparam int LANES_MAX = 4;
  localparam logic [alen-1:0] START_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    alu_op_e   alu_op;
    imm_type_e imm_type;
    logic      use_imm;
    logic      use_pc;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      jal;
    logic      jalr;
    logic      system;
    logic      fence;
    logic      illegal;
  } decode_bus;

  typedef struct packed {
    decode_bus        dec;
    logic [24:0]      inst;
    logic [alen-1:0]  pc;
  } dq_entry_t;

  // hi is inst[31:12]; returns the sign-extended J-type byte offset.
  function automatic logic [alen-1:0] jal_offset(input logic [19:0] hi);
    logic [20:0] imm;
    imm = {hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
    return {{(alen-21){imm[20]}}, imm};
  endfunction

endpackage

// File: rtl/intirvx_decode_decoder.sv
// Single-lane RV32I control decoder. Sees only the instruction fields that
// steer control: {funct7, inst[21:20], funct3, opcode}.
module intirvx_decode_decoder
  import intirvx_decode_mw_pkg::*;
(
  input  logic [18:0] fields,
  output decode_bus   dec
);

  logic [6:0] funct7_s;
  logic [1:0] rs2_lo_s;
  logic [2:0] funct3_s;
  logic [6:0] opcode_s;
  logic       alt_s;
  logic       f7_zero_s;

  assign {funct7_s, rs2_lo_s, funct3_s, opcode_s} = fields;
  assign alt_s     = (funct7_s == 7'b0100000);
  assign f7_zero_s = (funct7_s == 7'b0000000);

  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Opcode-driven control decode with illegal-encoding detection.
  always_comb begin
    dec          = '0;
    dec.alu_op   = ALU_ADD;
    dec.imm_type = IMM_NONE;
    case (opcode_s)
      OPC_LUI: begin
        dec.imm_type  = IMM_U;
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        dec.imm_type  = IMM_U;
        dec.use_imm   = 1'b1;
        dec.use_pc    = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.imm_type  = IMM_J;
        dec.use_pc    = 1'b1;
        dec.reg_write = 1'b1;
        dec.jal       = 1'b1;
      end
      OPC_JALR: begin
        dec.imm_type  = IMM_I;
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.jalr      = 1'b1;
        dec.illegal   = (funct3_s != 3'b000);
      end
      OPC_BRANCH: begin
        dec.imm_type = IMM_B;
        dec.branch   = 1'b1;
        // funct3[2:1] selects eq / lt / ltu comparison; 01 is reserved
        case (funct3_s[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm_type  = IMM_I;
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.illegal   = (funct3_s == 3'b011) || (funct3_s[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.imm_type  = IMM_S;
        dec.use_imm   = 1'b1;
        dec.mem_write = 1'b1;
        dec.illegal   = funct3_s[2] || (funct3_s == 3'b011);
      end
      OPC_OPIMM: begin
        dec.imm_type  = IMM_I;
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_sel(funct3_s, (funct3_s == 3'b101) && alt_s);
        if (funct3_s == 3'b001) begin
          dec.illegal = !f7_zero_s;
        end else if (funct3_s == 3'b101) begin
          dec.illegal = !(f7_zero_s || alt_s);
        end else begin
          dec.illegal = 1'b0;
        end
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_sel(funct3_s, alt_s);
        dec.illegal   = !(f7_zero_s ||
                          (alt_s && ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
      end
      OPC_FENCE: begin
        dec.fence = 1'b1;
      end
      OPC_SYSTEM: begin
        dec.system  = 1'b1;
        dec.illegal = (funct3_s == 3'b100) ||
                      ((funct3_s == 3'b000) && (rs2_lo_s == 2'b11));
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/intirvx_decode_mw.sv
// Multi-lane decode stage: owns the fetch PC and epoch, decodes LANES
// instructions per bundle and buffers the compacted ops in a DEPTH-entry ring.
module intirvx_decode_mw
  import intirvx_decode_mw_pkg::*;
#(
  parameter int              LANES      = 2,
  parameter int              DEPTH      = 8,
  parameter logic [alen-1:0] START_ADDR = START_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*32-1:0] f_inst,
  input  logic [alen-1:0]     f_pc,
  input  logic [LANES-1:0]    f_mask,
  input  logic                f_epoch,
  input  logic                f_valid,
  output logic                f_ready,
  output decode_bus           d_decode,
  output logic [24:0]         d_inst,
  output logic [alen-1:0]     d_pc,
  output logic                d_valid,
  input  logic                d_ready,
  input  logic                alu_jump,
  input  logic [xlen-1:0]     alu_jump_addr,
  input  logic                alu_valid,
  output logic                alu_ready,
  output logic [alen-1:0]     pc,
  output logic                pc_epoch,
  output logic                pc_valid,
  input  logic                pc_ready,
  output logic                flush_ifetch,
  input  logic                flush
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(LANES + 1);
  localparam logic [alen-1:0] PC_STEP = alen'(32'd4 * LANES);

  logic [alen-1:0] pc_r;
  logic            pc_valid_r;
  logic            epoch_r;
  logic            flush_ifetch_r;

  dq_entry_t       mem_r [DEPTH];
  logic [PW-1:0]   rd_r;
  logic [PW-1:0]   wr_r;
  logic [CW-1:0]   count_r;

  logic [31:0]     lane_inst_s  [LANES];
  logic [alen-1:0] lane_pc_s    [LANES];
  decode_bus       lane_dec_s   [LANES];
  dq_entry_t       lane_entry_s [LANES];
  logic [NW-1:0]   pos_s        [LANES];
  logic [LANES-1:0] keep_s;
  logic [NW-1:0]   n_s;
  logic [NW-1:0]   enq_n_s;
  logic            jal_found_s;
  logic [alen-1:0] jal_target_s;
  logic            redirect_alu_s;
  logic            accept_s;
  logic            jal_taken_s;
  logic            deq_s;
  logic            clear_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_inst_s[g] = f_inst[32*g +: 32];
    assign lane_pc_s[g]   = f_pc + alen'(32'(g) * 32'd4);

    intirvx_decode_decoder u_dec (
      .fields ({lane_inst_s[g][31:25], lane_inst_s[g][21:20],
                lane_inst_s[g][14:12], lane_inst_s[g][6:0]}),
      .dec    (lane_dec_s[g])
    );

    assign lane_entry_s[g] = '{dec: lane_dec_s[g], inst: lane_inst_s[g][31:7], pc: lane_pc_s[g]};
  end

  assign redirect_alu_s = alu_valid & alu_jump;
  assign f_ready        = (count_r <= CW'(DEPTH - LANES));
  assign accept_s       = f_valid & f_ready & (f_epoch == epoch_r) & ~redirect_alu_s;
  assign jal_taken_s    = accept_s & jal_found_s;
  assign d_valid        = (count_r != '0);
  assign deq_s          = d_valid & d_ready;
  assign clear_s        = flush | redirect_alu_s;

  // Lane compaction: set lanes take consecutive slots; the first JAL ends the bundle.
  always_comb begin
    keep_s       = '0;
    n_s          = '0;
    jal_found_s  = 1'b0;
    jal_target_s = '0;
    for (int i = 0; i < LANES; i++) begin
      pos_s[i] = n_s;
      if (f_mask[i] && !jal_found_s) begin
        keep_s[i] = 1'b1;
        n_s       = n_s + NW'(1);
        if (lane_dec_s[i].jal) begin
          jal_found_s  = 1'b1;
          jal_target_s = lane_pc_s[i] + jal_offset(lane_inst_s[i][31:12]);
        end else begin
          jal_found_s  = 1'b0;
        end
      end else begin
        keep_s[i] = 1'b0;
      end
    end
  end

  // Number of ops entering the ring this cycle.
  always_comb begin
    if (accept_s) begin
      enq_n_s = n_s;
    end else begin
      enq_n_s = '0;
    end
  end

  // Ring storage; stale contents are harmless because count gates visibility.
  always_ff @(posedge clk) begin
    if (accept_s && !flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (keep_s[i]) begin
          mem_r[wr_r + PW'(pos_s[i])] <= lane_entry_s[i];
        end
      end
    end
  end

  // Ring pointers and occupancy; a clear beats any same-cycle enqueue/dequeue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_r    <= '0;
      wr_r    <= '0;
      count_r <= '0;
    end else if (clear_s) begin
      rd_r    <= '0;
      wr_r    <= '0;
      count_r <= '0;
    end else begin
      wr_r    <= wr_r + PW'(enq_n_s);
      rd_r    <= rd_r + PW'(deq_s);
      count_r <= count_r + CW'(enq_n_s) - CW'(deq_s);
    end
  end

  // Fetch PC / epoch sequencer: ALU redirect beats JAL beats sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r           <= START_ADDR;
      pc_valid_r     <= 1'b0;
      epoch_r        <= 1'b0;
      flush_ifetch_r <= 1'b0;
    end else begin
      pc_valid_r     <= 1'b1;
      flush_ifetch_r <= redirect_alu_s | jal_taken_s;
      if (redirect_alu_s) begin
        pc_r    <= alu_jump_addr[alen-1:0];
        epoch_r <= ~epoch_r;
      end else if (jal_taken_s) begin
        pc_r    <= jal_target_s;
        epoch_r <= ~epoch_r;
      end else if (pc_valid_r && pc_ready) begin
        pc_r    <= pc_r + PC_STEP;
      end
    end
  end

  assign d_decode     = mem_r[rd_r].dec;
  assign d_inst       = mem_r[rd_r].inst;
  assign d_pc         = mem_r[rd_r].pc;
  assign alu_ready    = 1'b1;
  assign pc           = pc_r;
  assign pc_epoch     = epoch_r;
  assign pc_valid     = pc_valid_r;
  assign flush_ifetch = flush_ifetch_r;

endmodule

// File: tb/tb_intirvx_decode_mw.sv
// Self-checking bench for intirvx_decode_mw (LANES=2, DEPTH=8, START_ADDR=0)
// using a queue-based reference model of the fetch/decode behaviour.
module tb_intirvx_decode_mw;
  import intirvx_decode_mw_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0113;
  localparam logic [31:0] JAL40 = 32'h0400_006F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] f_inst;
  logic [31:0] f_pc;
  logic [1:0]  f_mask;
  logic        f_epoch, f_valid, f_ready;
  decode_bus   d_decode;
  logic [24:0] d_inst;
  logic [31:0] d_pc;
  logic        d_valid, d_ready;
  logic        alu_jump, alu_valid, alu_ready;
  logic [31:0] alu_jump_addr;
  logic [31:0] pc;
  logic        pc_epoch, pc_valid, pc_ready, flush_ifetch, flush;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_epoch, m_pc_valid, m_flush_exp;

  intirvx_decode_mw #(.LANES(LANES), .DEPTH(DEPTH), .START_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .f_inst(f_inst), .f_pc(f_pc), .f_mask(f_mask),
    .f_epoch(f_epoch), .f_valid(f_valid), .f_ready(f_ready),
    .d_decode(d_decode), .d_inst(d_inst), .d_pc(d_pc), .d_valid(d_valid),
    .d_ready(d_ready), .alu_jump(alu_jump), .alu_jump_addr(alu_jump_addr),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .pc(pc), .pc_epoch(pc_epoch),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .flush_ifetch(flush_ifetch), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] jal_off(input logic [31:0] ins);
    int off;
    off = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096;
    if (ins[31]) off = off - 1048576;
    return off;
  endfunction

  function automatic void model_init();
    m_q.delete();
    m_pc = 32'h0;
    m_epoch = 1'b0;
    m_pc_valid = 1'b0;
    m_flush_exp = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    bit redirect, fr, acc, deq, jal;
    logic [31:0] tgt;
    exp_t e;
    exp_t newq[$];
    redirect = alu_valid && alu_jump;
    fr  = (DEPTH - m_q.size()) >= LANES;
    acc = f_valid && fr && (f_epoch == m_epoch) && !redirect;
    deq = (m_q.size() != 0) && d_ready;
    jal = 0;
    tgt = 32'h0;
    for (int i = 0; i < LANES; i++) begin
      if (f_mask[i] && !jal) begin
        e.pc = f_pc + 32'(4 * i);
        e.inst = f_inst[32*i +: 32];
        newq.push_back(e);
        if (e.inst[6:0] == 7'h6F) begin
          jal = 1;
          tgt = e.pc + jal_off(e.inst);
        end
      end
    end
    if (redirect || flush) m_q.delete();
    else begin
      if (deq) void'(m_q.pop_front());
      if (acc) foreach (newq[k]) m_q.push_back(newq[k]);
    end
    m_flush_exp = 1'b0;
    if (redirect) begin
      m_pc = alu_jump_addr; m_epoch = ~m_epoch; m_flush_exp = 1'b1;
    end else if (acc && jal) begin
      m_pc = tgt; m_epoch = ~m_epoch; m_flush_exp = 1'b1;
    end else if (m_pc_valid && pc_ready) begin
      m_pc = m_pc + 32'd8;
    end
    m_pc_valid = 1'b1;
  endfunction

  task automatic set_idle();
    f_inst = 64'h0; f_pc = 32'h0; f_mask = 2'b00; f_epoch = 1'b0; f_valid = 1'b0;
    d_ready = 1'b0; alu_jump = 1'b0; alu_valid = 1'b0; alu_jump_addr = 32'h0;
    pc_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_bundle(input logic [31:0] pc0, input logic [31:0] i0,
                              input logic [31:0] i1, input logic [1:0] m);
    f_pc = pc0; f_inst = {i1, i0}; f_mask = m; f_epoch = m_epoch; f_valid = 1'b1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL reset_pc_valid got=%b exp=0", pc_valid); end
    checks++; if (pc_epoch !== 1'b0) begin failures++; $display("FAIL reset_epoch got=%b exp=0", pc_epoch); end
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL reset_d_valid got=%b exp=0", d_valid); end
    checks++; if (flush_ifetch !== 1'b0) begin failures++; $display("FAIL reset_flush_ifetch got=%b exp=0", flush_ifetch); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%b exp=1", alu_ready); end
    rst = 1'b0;
    model_init();
    step();
    checks++; if (pc_valid !== 1'b1) begin failures++; $display("FAIL release_pc_valid got=%b exp=1", pc_valid); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL release_pc got=%h exp=%h", pc, 32'h0); end
  endtask

  task automatic test_pc_advance();
    pc_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (pc !== 32'(8 * k)) begin failures++; $display("FAIL pc_advance got=%h exp=%h", pc, 32'(8 * k)); end
    end
    pc_ready = 1'b0;
  endtask

  task automatic test_addi_pair();
    drive_bundle(32'h100, ADDI1, ADDI2, 2'b11);
    d_ready = 1'b1;
    step();
    f_valid = 1'b0;
    checks++; if (d_valid !== 1'b1 || d_pc !== 32'h100) begin failures++; $display("FAIL addi_head0 got=%b/%h exp=1/%h", d_valid, d_pc, 32'h100); end
    checks++; if (d_inst !== ADDI1[31:7]) begin failures++; $display("FAIL addi_inst got=%h exp=%h", d_inst, ADDI1[31:7]); end
    checks++; if (d_decode.alu_op !== ALU_ADD || d_decode.use_imm !== 1'b1) begin failures++; $display("FAIL addi_decode got=%0d/%b exp=0/1", d_decode.alu_op, d_decode.use_imm); end
    step();
    checks++; if (d_valid !== 1'b1 || d_pc !== 32'h104) begin failures++; $display("FAIL addi_head1 got=%b/%h exp=1/%h", d_valid, d_pc, 32'h104); end
    step();
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL addi_drained got=%b exp=0", d_valid); end
    d_ready = 1'b0;
  endtask

  task automatic test_jal();
    logic old;
    old = m_epoch;
    drive_bundle(32'h200, JAL40, ADDI1, 2'b11);
    step();
    f_valid = 1'b0;
    checks++; if (pc !== 32'h240) begin failures++; $display("FAIL jal_pc got=%h exp=%h", pc, 32'h240); end
    checks++; if (flush_ifetch !== 1'b1) begin failures++; $display("FAIL jal_flush_ifetch got=%b exp=1", flush_ifetch); end
    checks++; if (pc_epoch !== ~old) begin failures++; $display("FAIL jal_epoch got=%b exp=%b", pc_epoch, ~old); end
    checks++; if (d_pc !== 32'h200 || d_decode.jal !== 1'b1) begin failures++; $display("FAIL jal_head got=%h/%b exp=%h/1", d_pc, d_decode.jal, 32'h200); end
    drive_bundle(32'h240, ADDI1, ADDI2, 2'b11);
    f_epoch = old;
    checks++; if (f_ready !== 1'b1) begin failures++; $display("FAIL stale_f_ready got=%b exp=1", f_ready); end
    step();
    f_valid = 1'b0;
    d_ready = 1'b1;
    checks++; if (flush_ifetch !== 1'b0) begin failures++; $display("FAIL jal_pulse_width got=%b exp=0", flush_ifetch); end
    step();
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL stale_dropped got=%b exp=0", d_valid); end
    checks++; if (pc !== 32'h240 || pc_epoch !== ~old) begin failures++; $display("FAIL stale_pc got=%h/%b exp=%h/%b", pc, pc_epoch, 32'h240, ~old); end
    d_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int b = 0; b < 3; b++) begin
      drive_bundle(32'h300 + 32'(8 * b), ADDI1, ADDI2, 2'b11);
      step();
    end
    f_valid = 1'b0;
    checks++; if (f_ready !== 1'b1) begin failures++; $display("FAIL full_six_ready got=%b exp=1", f_ready); end
    drive_bundle(32'h318, ADDI1, ADDI2, 2'b11);
    step();
    f_valid = 1'b0;
    checks++; if (f_ready !== 1'b0) begin failures++; $display("FAIL full_eight_ready got=%b exp=0", f_ready); end
    drive_bundle(32'h320, ADDI1, ADDI2, 2'b11);
    d_ready = 1'b1;
    checks++; if (f_ready !== 1'b0) begin failures++; $display("FAIL full_deq_ready got=%b exp=0", f_ready); end
    step();
    f_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++; if (d_valid !== 1'b1 || d_pc !== 32'h304 + 32'(4 * k)) begin failures++; $display("FAIL full_drain got=%b/%h exp=1/%h", d_valid, d_pc, 32'h304 + 32'(4 * k)); end
      step();
    end
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", d_valid); end
    d_ready = 1'b0;
  endtask

  task automatic test_alu_redirect();
    logic old;
    drive_bundle(32'h480, ADDI1, ADDI2, 2'b11);
    step();
    old = m_epoch;
    drive_bundle(32'h500, JAL40, ADDI1, 2'b11);
    alu_valid = 1'b1; alu_jump = 1'b1; alu_jump_addr = 32'h400;
    step();
    f_valid = 1'b0; alu_valid = 1'b0; alu_jump = 1'b0;
    checks++; if (pc !== 32'h400) begin failures++; $display("FAIL redirect_pc got=%h exp=%h", pc, 32'h400); end
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL redirect_queue got=%b exp=0", d_valid); end
    checks++; if (pc_epoch !== ~old) begin failures++; $display("FAIL redirect_epoch got=%b exp=%b", pc_epoch, ~old); end
    checks++; if (flush_ifetch !== 1'b1) begin failures++; $display("FAIL redirect_flush_ifetch got=%b exp=1", flush_ifetch); end
  endtask

  task automatic test_flush();
    drive_bundle(32'h600, ADDI1, ADDI2, 2'b11); step();
    drive_bundle(32'h608, ADDI1, ADDI2, 2'b11); step();
    drive_bundle(32'h610, ADDI1, ADDI2, 2'b01); step();
    f_valid = 1'b0;
    checks++; if (d_valid !== 1'b1 || d_pc !== 32'h600) begin failures++; $display("FAIL flush_pre got=%b/%h exp=1/%h", d_valid, d_pc, 32'h600); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL flush_queue got=%b exp=0", d_valid); end
    checks++; if (pc !== m_pc || pc_epoch !== m_epoch) begin failures++; $display("FAIL flush_pc got=%h/%b exp=%h/%b", pc, pc_epoch, m_pc, m_epoch); end
    checks++; if (flush_ifetch !== 1'b0) begin failures++; $display("FAIL flush_no_redirect got=%b exp=0", flush_ifetch); end
  endtask

  task automatic test_async_reset();
    drive_bundle(32'h700, JAL40, ADDI1, 2'b01);
    pc_ready = 1'b1;
    step();
    #3 rst = 1'b1;
    #1;
    checks++; if (d_valid !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL async_rst got=%b/%h exp=0/%h", d_valid, pc, 32'h0); end
    checks++; if (pc_valid !== 1'b0 || pc_epoch !== 1'b0) begin failures++; $display("FAIL async_rst_ctl got=%b/%b exp=0/0", pc_valid, pc_epoch); end
    set_idle();
    #2 rst = 1'b0;
    model_init();
    step();
    checks++; if (pc_valid !== 1'b1 || d_valid !== 1'b0) begin failures++; $display("FAIL async_release got=%b/%b exp=1/0", pc_valid, d_valid); end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return {r[31:7], 7'h13};
      1: return {r[31:7], 7'h6F};
      2: return {r[31:7], 7'h33};
      3: return {r[31:7], 7'h03};
      default: return r;
    endcase
  endfunction

  task automatic test_random();
    exp_t h;
    bit exp_fr;
    for (int n = 0; n < 400; n++) begin
      f_inst = {rand_inst(), rand_inst()};
      f_pc = $urandom & 32'hFFFF_FFFC;
      f_mask = 2'($urandom_range(0, 3));
      f_valid = 1'($urandom_range(0, 1));
      f_epoch = ($urandom_range(0, 3) == 0) ? ~m_epoch : m_epoch;
      d_ready = ($urandom_range(0, 2) != 0);
      pc_ready = 1'($urandom_range(0, 1));
      alu_valid = ($urandom_range(0, 15) == 0);
      alu_jump = 1'($urandom_range(0, 1));
      alu_jump_addr = $urandom & 32'hFFFF_FFFC;
      flush = ($urandom_range(0, 31) == 0);
      exp_fr = (DEPTH - m_q.size()) >= LANES;
      checks++; if (f_ready !== exp_fr) begin failures++; $display("FAIL rnd_f_ready cyc=%0d got=%b exp=%b", n, f_ready, exp_fr); end
      checks++; if (d_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_d_valid cyc=%0d got=%b exp=%b", n, d_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        h = m_q[0];
        checks++; if (d_pc !== h.pc || d_inst !== h.inst[31:7]) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", n, d_pc, d_inst, h.pc, h.inst[31:7]); end
        checks++; if (d_decode.jal !== (h.inst[6:0] == 7'h6F)) begin failures++; $display("FAIL rnd_jal_bit cyc=%0d got=%b", n, d_decode.jal); end
      end
      step();
      checks++; if (pc !== m_pc || pc_epoch !== m_epoch) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h/%b exp=%h/%b", n, pc, pc_epoch, m_pc, m_epoch); end
      checks++; if (flush_ifetch !== m_flush_exp) begin failures++; $display("FAIL rnd_flush_ifetch cyc=%0d got=%b exp=%b", n, flush_ifetch, m_flush_exp); end
    end
    set_idle();
  endtask

  initial begin
    model_init();
    test_reset();
    test_pc_advance();
    test_addi_pair();
    test_jal();
    test_full();
    test_alu_redirect();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
